// File: rtl/alarm_pkg.sv
// Shared state encoding and helpers for the multi-zone alarm controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    DISARMED    = 3'd0,
    EXIT_DELAY  = 3'd1,
    ARMED       = 3'd2,
    ENTRY_DELAY = 3'd3,
    ALARM       = 3'd4,
    PANIC       = 3'd5
  } alarm_state_t;

  localparam int STATE_W = 3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_tick_timer.sv
// Tick-driven down-counter: load wins over decrement, saturates at zero,
// and flags the tick that takes it from 1 to 0.
module alarm_tick_timer #(
  parameter int W = 4
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (tick && count != '0)
      count <= count - W'(1);
  end

  assign done = tick && (count == W'(1));

endmodule

// File: rtl/multi_zone_alarm.sv
// Multi-zone intrusion alarm sequencer with exit/entry delays, siren timeout
// and a flashing strobe.
//   state       | meaning
//   DISARMED    | idle, zones only gate arming
//   EXIT_DELAY  | occupant leaving, zones ignored
//   ARMED       | watching all active zones
//   ENTRY_DELAY | delayed zone tripped, waiting for disarm
//   ALARM       | intrusion, siren until timeout, strobe flashing
//   PANIC       | manual alarm, siren and strobe until disarmed
module multi_zone_alarm
  import alarm_pkg::*;
#(
  parameter int N_ZONES      = 3,
  parameter int EXIT_TICKS   = 20,
  parameter int ENTRY_TICKS  = 20,
  parameter int STROBE_TICKS = 8,
  parameter int SIREN_TICKS  = 600
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               tick,
  input  logic               arm_req,
  input  logic               disarm_req,
  input  logic               panic_req,
  input  logic [N_ZONES-1:0] zone_in,
  input  logic [N_ZONES-1:0] zone_mask,
  input  logic [N_ZONES-1:0] zone_instant,
  output logic [STATE_W-1:0] state,
  output logic               siren,
  output logic               strobe,
  output logic [N_ZONES-1:0] zone_latched,
  output logic               arm_fail,
  output logic               armed_led,
  output logic               disarmed_led
);

  localparam int DLY_W = $clog2(max2(EXIT_TICKS, ENTRY_TICKS) + 1);
  localparam int STB_W = $clog2(STROBE_TICKS + 1);
  localparam int SRN_W = $clog2(SIREN_TICKS + 1);

  alarm_state_t state_q, state_d;
  logic [N_ZONES-1:0] act;
  logic inst_hit, dly_hit;
  logic arm_fail_d, siren_d, strobe_d;
  logic dly_load, dly_done, stb_load, stb_done, srn_done;
  logic enter_alarm, strobe_on_d, strobe_restart;
  logic [DLY_W-1:0] dly_val;

  assign act      = zone_in & ~zone_mask;
  assign inst_hit = |(act & zone_instant);
  assign dly_hit  = |(act & ~zone_instant);

  always_comb begin
    state_d    = state_q;
    arm_fail_d = 1'b0;
    if (panic_req)
      state_d = PANIC;
    else if (disarm_req)
      state_d = DISARMED;
    else begin
      case (state_q)
        DISARMED:
          if (arm_req) begin
            if (act == '0) state_d = EXIT_DELAY;
            else           arm_fail_d = 1'b1;
          end
        EXIT_DELAY:  if (dly_done) state_d = ARMED;
        ARMED:
          if (inst_hit)     state_d = ALARM;
          else if (dly_hit) state_d = ENTRY_DELAY;
        ENTRY_DELAY: if (inst_hit || dly_done) state_d = ALARM;
        ALARM, PANIC: state_d = state_q;
        default:      state_d = DISARMED;
      endcase
    end
  end

  // One timer serves both delays; it is reloaded on the edge that enters either.
  always_comb begin
    dly_load = ((state_d == EXIT_DELAY) && (state_q != EXIT_DELAY)) ||
               ((state_d == ENTRY_DELAY) && (state_q != ENTRY_DELAY));
    dly_val  = (state_d == EXIT_DELAY) ? DLY_W'(EXIT_TICKS) : DLY_W'(ENTRY_TICKS);
  end

  // A repeated panic counts as a fresh entry so the strobe phase restarts.
  always_comb begin
    enter_alarm    = (state_d == ALARM) && (state_q != ALARM);
    strobe_on_d    = (state_d == ALARM) || (state_d == PANIC);
    strobe_restart = enter_alarm || panic_req;
    stb_load       = strobe_restart || stb_done;

    siren_d = 1'b0;
    if (state_d == PANIC)
      siren_d = 1'b1;
    else if (state_d == ALARM)
      siren_d = enter_alarm ? 1'b1 : (siren && !srn_done);

    strobe_d = 1'b0;
    if (strobe_on_d) begin
      if (strobe_restart) strobe_d = 1'b1;
      else if (stb_done)  strobe_d = ~strobe;
      else                strobe_d = strobe;
    end
  end

  alarm_tick_timer #(.W(DLY_W)) u_dly_timer (
    .iCLK(iCLK), .iRST(iRST), .tick(tick),
    .load(dly_load), .load_val(dly_val), .done(dly_done)
  );

  alarm_tick_timer #(.W(STB_W)) u_stb_timer (
    .iCLK(iCLK), .iRST(iRST), .tick(tick),
    .load(stb_load), .load_val(STB_W'(STROBE_TICKS)), .done(stb_done)
  );

  alarm_tick_timer #(.W(SRN_W)) u_srn_timer (
    .iCLK(iCLK), .iRST(iRST), .tick(tick),
    .load(enter_alarm), .load_val(SRN_W'(SIREN_TICKS)), .done(srn_done)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q      <= DISARMED;
      siren        <= 1'b0;
      strobe       <= 1'b0;
      zone_latched <= '0;
      arm_fail     <= 1'b0;
      armed_led    <= 1'b0;
      disarmed_led <= 1'b1;
    end else begin
      state_q      <= state_d;
      siren        <= siren_d;
      strobe       <= strobe_d;
      arm_fail     <= arm_fail_d;
      armed_led    <= state_d inside {ARMED, ENTRY_DELAY, ALARM, PANIC};
      disarmed_led <= state_d inside {DISARMED, EXIT_DELAY};
      if ((state_q == DISARMED) && (state_d == EXIT_DELAY))
        zone_latched <= '0;
      else if (state_q inside {ARMED, ENTRY_DELAY, ALARM})
        zone_latched <= zone_latched | act;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multi_zone_alarm.sv
// Scoreboard bench for multi_zone_alarm: expectations are queued as stimulus
// is applied and checked just after the clock edge that should produce them.
module tb_multi_zone_alarm;

  localparam int S_STATE = 0, S_SIREN = 1, S_STROBE = 2, S_ZL = 3,
                 S_FAIL = 4, S_ARMED = 5, S_DISARMED = 6;

  logic iCLK, iRST, tick, arm_req, disarm_req, panic_req;
  logic [3:0] zone_in, zone_mask, zone_instant, zone_latched;
  logic [2:0] state;
  logic siren, strobe, arm_fail, armed_led, disarmed_led;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  multi_zone_alarm #(
    .N_ZONES(4), .EXIT_TICKS(3), .ENTRY_TICKS(2),
    .STROBE_TICKS(2), .SIREN_TICKS(8)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .tick(tick),
    .arm_req(arm_req), .disarm_req(disarm_req), .panic_req(panic_req),
    .zone_in(zone_in), .zone_mask(zone_mask), .zone_instant(zone_instant),
    .state(state), .siren(siren), .strobe(strobe),
    .zone_latched(zone_latched), .arm_fail(arm_fail),
    .armed_led(armed_led), .disarmed_led(disarmed_led)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] get(input int sel);
    case (sel)
      S_STATE:    return {29'd0, state};
      S_SIREN:    return {31'd0, siren};
      S_STROBE:   return {31'd0, strobe};
      S_ZL:       return {28'd0, zone_latched};
      S_FAIL:     return {31'd0, arm_fail};
      S_ARMED:    return {31'd0, armed_led};
      S_DISARMED: return {31'd0, disarmed_led};
      default:    return '1;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    sb_q.push_back('{tag, sel, exp});
  endtask

  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, get(e.sel), e.exp);
    end
  endtask

  // tick is high during every cycle whose index is a multiple of 4
  task automatic clk1();
    @(posedge iCLK);
    #1;
    drain();
    cyc++;
    tick = (cyc % 4 == 0);
  endtask

  task automatic align(input int r);
    for (int n = 0; n < 8 && (cyc % 4) != r; n++) clk1();
  endtask

  task automatic to_tick();
    for (int n = 0; n < 8 && !tick; n++) clk1();
  endtask

  // arm in a quiet cycle, then expect ARMED exactly on the 3rd tick
  task automatic arm_to_armed(input string tag);
    align(2);
    arm_req = 1'b1;
    push({tag, "_exit"}, S_STATE, 1);
    push({tag, "_zl_clr"}, S_ZL, 0);
    clk1();
    arm_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      to_tick();
      push($sformatf("%s_tick%0d", tag, k), S_STATE, (k < 3) ? 1 : 2);
      clk1();
    end
  endtask

  initial begin
    iRST = 1'b1; tick = 1'b0;
    arm_req = 1'b0; disarm_req = 1'b0; panic_req = 1'b0;
    zone_in = 4'b0000; zone_mask = 4'b0000; zone_instant = 4'b0100;
    repeat (3) @(posedge iCLK);
    #1;
    chk("rst_state", {29'd0, state}, 0);
    chk("rst_disarmed_led", {31'd0, disarmed_led}, 1);
    chk("rst_armed_led", {31'd0, armed_led}, 0);
    chk("rst_siren", {31'd0, siren}, 0);
    chk("rst_strobe", {31'd0, strobe}, 0);
    chk("rst_zl", {28'd0, zone_latched}, 0);
    iRST = 1'b0;

    // idle with no request: nothing moves, even across a tick
    for (int i = 0; i < 5; i++) begin
      push("idle_state", S_STATE, 0);
      clk1();
    end

    // refused arm with an unmasked tripped zone
    zone_in = 4'b0010;
    align(2);
    arm_req = 1'b1;
    push("armfail_pulse", S_FAIL, 1);
    push("armfail_state", S_STATE, 0);
    clk1();
    arm_req = 1'b0;
    push("armfail_drop", S_FAIL, 0);
    push("armfail_state2", S_STATE, 0);
    clk1();

    // bypass zone 1, arm succeeds
    zone_mask = 4'b0010;
    arm_to_armed("arm1");
    push("arm1_led", S_ARMED, 1);
    push("arm1_dled", S_DISARMED, 0);
    clk1();

    // delayed zone 0 trip -> ENTRY_DELAY -> ALARM after 2 ticks
    zone_in = 4'b0011;
    push("entry_state", S_STATE, 3);
    push("entry_zl", S_ZL, 4'b0001);
    clk1();
    zone_in = 4'b0010;
    for (int k = 1; k <= 2; k++) begin
      to_tick();
      push($sformatf("entry_tick%0d", k), S_STATE, (k < 2) ? 3 : 4);
      clk1();
    end
    push("alarm_siren", S_SIREN, 1);
    push("alarm_strobe", S_STROBE, 1);
    push("alarm_zl", S_ZL, 4'b0001);
    clk1();
    disarm_req = 1'b1;
    push("disarm_state", S_STATE, 0);
    push("disarm_siren", S_SIREN, 0);
    push("disarm_strobe", S_STROBE, 0);
    push("disarm_zl_hold", S_ZL, 4'b0001);
    clk1();
    disarm_req = 1'b0;

    // instant zone 2 trip: ALARM next cycle, strobe and siren timing
    arm_to_armed("arm2");
    zone_in = 4'b0110;
    push("inst_state", S_STATE, 4);
    push("inst_siren", S_SIREN, 1);
    push("inst_strobe", S_STROBE, 1);
    push("inst_zl", S_ZL, 4'b0100);
    clk1();
    zone_in = 4'b0010;
    for (int t = 1; t <= 9; t++) begin
      to_tick();
      push($sformatf("strobe_t%0d", t), S_STROBE, ((t / 2) % 2 == 0) ? 1 : 0);
      push($sformatf("siren_t%0d", t), S_SIREN, (t < 8) ? 1 : 0);
      push($sformatf("alarm_hold_t%0d", t), S_STATE, 4);
      clk1();
    end
    disarm_req = 1'b1;
    push("disarm2_state", S_STATE, 0);
    clk1();
    disarm_req = 1'b0;

    // disarm coinciding with the expiring entry tick wins
    arm_to_armed("arm3");
    zone_in = 4'b0011;
    push("entry3_state", S_STATE, 3);
    clk1();
    zone_in = 4'b0010;
    to_tick();
    push("entry3_tick1", S_STATE, 3);
    clk1();
    to_tick();
    disarm_req = 1'b1;
    push("entry3_disarm", S_STATE, 0);
    push("entry3_zl", S_ZL, 4'b0001);
    push("entry3_dled", S_DISARMED, 1);
    push("entry3_siren", S_SIREN, 0);
    clk1();
    disarm_req = 1'b0;

    // panic outranks a simultaneous disarm; repeat panic restarts strobe
    arm_to_armed("arm4");
    panic_req = 1'b1; disarm_req = 1'b1;
    push("panic_state", S_STATE, 5);
    push("panic_siren", S_SIREN, 1);
    push("panic_strobe", S_STROBE, 1);
    push("panic_led", S_ARMED, 1);
    clk1();
    panic_req = 1'b0; disarm_req = 1'b0;
    for (int t = 1; t <= 2; t++) begin
      to_tick();
      push($sformatf("panic_strobe_t%0d", t), S_STROBE, (t < 2) ? 1 : 0);
      push($sformatf("panic_siren_t%0d", t), S_SIREN, 1);
      clk1();
    end
    panic_req = 1'b1;
    push("repanic_state", S_STATE, 5);
    push("repanic_strobe", S_STROBE, 1);
    clk1();
    panic_req = 1'b0;
    disarm_req = 1'b1;
    push("panic_exit_state", S_STATE, 0);
    push("panic_exit_siren", S_SIREN, 0);
    clk1();
    disarm_req = 1'b0;

    // asynchronous reset in the middle of the exit delay
    align(2);
    arm_req = 1'b1;
    push("pre_rst_state", S_STATE, 1);
    clk1();
    arm_req = 1'b0;
    clk1();
    #3;
    iRST = 1'b1;
    #1;
    chk("async_rst_state", {29'd0, state}, 0);
    chk("async_rst_dled", {31'd0, disarmed_led}, 1);
    chk("async_rst_armed", {31'd0, armed_led}, 0);
    chk("async_rst_zl", {28'd0, zone_latched}, 0);
    chk("async_rst_fail", {31'd0, arm_fail}, 0);
    clk1();
    clk1();
    iRST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push("post_rst_state", S_STATE, 0);
      clk1();
    end
    arm_to_armed("arm5");
    clk1();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
